// File: rtl/axi_stream_if.sv
// AXI-Stream bundle shared by the segmenter's payload input and segment output.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/tcp_tx_segmenter.sv
// TCP transmit segmenter: sequence-indexed retransmit buffer, MSS/window-bounded segments, go-back-N.
// Optional TCP_TX_NAGLE_EN holds sub-MSS segments until everything sent has been acknowledged.
`ifndef INPUTWIDTH
`define INPUTWIDTH 32
`endif
module tcp_tx_segmenter #(
    parameter int DATA_WIDTH = `INPUTWIDTH,
    parameter int DEPTH      = 1024,
    parameter int SEQ_BITS   = 32,
    parameter int MSS        = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_stream_if.slave         s_axis,
    axi_stream_if.master        m_axis,
    input  logic [SEQ_BITS-1:0] seq_base,
    input  logic                base_valid,
    input  logic [SEQ_BITS-1:0] ack_num,
    input  logic                ack_valid,
    input  logic [31:0]         window_size,
    input  logic                retx_req,
    output logic [SEQ_BITS-1:0] seg_seq,
    output logic [15:0]         seg_len,
    output logic [SEQ_BITS-1:0] unacked
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(BYTES) + 1;
    localparam int CW    = ((SEQ_BITS > 32) ? SEQ_BITS : 32) + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    function automatic logic [PW-1:0] popcount(input logic [BYTES-1:0] keep);
        logic [PW-1:0] cnt;
        cnt = {PW{1'b0}};
        for (int i = 0; i < BYTES; i++) cnt = cnt + PW'(keep[i]);
        return cnt;
    endfunction

    logic [7:0]            mem [DEPTH];
    logic [0:0]            state_r, state_s;
    logic [SEQ_BITS-1:0]   snd_una_r, snd_una_s, snd_nxt_r, snd_nxt_s;
    logic [SEQ_BITS-1:0]   wr_seq_r, wr_seq_s, psh_seq_r, psh_seq_s;
    logic [SEQ_BITS-1:0]   seg_seq_r, seg_seq_s, unacked_r, unacked_s, rd_seq_r, rd_seq_s;
    logic [15:0]           seg_len_r, seg_len_s, rem_r, rem_s;
    logic                  retx_pend_r, retx_pend_s, tvalid_r, tvalid_s, tlast_r, tlast_s;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_s, ld_data_s;
    logic [BYTES-1:0]      tkeep_r, tkeep_s, ld_keep_s;
    logic [SEQ_BITS-1:0]   space_s, avail_s, psh_gap_s, ack_diff_s, ld_seq_s;
    logic [CW-1:0]         room_s, len_ext_s;
    logic [15:0]           len_s, ld_cnt_s, ld_nb_s;
    logic                  tready_s, s_hs_s, m_hs_s, ack_ok_s, start_s, short_ok_s;
    logic                  unused_s;

    assign space_s    = SEQ_BITS'(DEPTH) - (wr_seq_r - snd_una_r);
    assign tready_s   = rst_n && (space_s >= SEQ_BITS'(BYTES));
    assign s_hs_s     = s_axis.tvalid && tready_s;
    assign m_hs_s     = tvalid_r && m_axis.tready;
    assign avail_s    = wr_seq_r - snd_nxt_r;
    assign psh_gap_s  = psh_seq_r - snd_nxt_r;
    assign ack_diff_s = ack_num - snd_una_r;
    assign ack_ok_s   = ack_valid && (ack_diff_s != {SEQ_BITS{1'b0}}) && (ack_diff_s <= unacked_r);
    assign unused_s   = s_axis.tuser;

    // Segment length from MSS, remaining window and buffered bytes, plus the IDLE start decision.
    always_comb begin
        room_s    = (CW'(window_size) > CW'(unacked_r)) ? CW'(window_size) - CW'(unacked_r) : {CW{1'b0}};
        len_ext_s = CW'(MSS);
        if (room_s < len_ext_s) len_ext_s = room_s;
        else len_ext_s = len_ext_s;
        if (CW'(avail_s) < len_ext_s) len_ext_s = CW'(avail_s);
        else len_ext_s = len_ext_s;
        len_s      = 16'(len_ext_s);
        short_ok_s = (psh_gap_s != {SEQ_BITS{1'b0}}) && (psh_gap_s <= avail_s) && (len_s != 16'd0);
`ifdef TCP_TX_NAGLE_EN
        start_s = (len_s == 16'(MSS)) || (short_ok_s && (unacked_r == {SEQ_BITS{1'b0}}));
`else
        start_s = (len_s == 16'(MSS)) || short_ok_s;
`endif
    end

    // Build the next output beat: first beat of a new segment in IDLE, following beat in EMIT.
    always_comb begin
        ld_seq_s  = (state_r == ST_IDLE) ? snd_nxt_r : rd_seq_r;
        ld_cnt_s  = (state_r == ST_IDLE) ? len_s : rem_r;
        ld_nb_s   = (ld_cnt_s >= 16'(BYTES)) ? 16'(BYTES) : ld_cnt_s;
        ld_data_s = {DATA_WIDTH{1'b0}};
        ld_keep_s = {BYTES{1'b0}};
        for (int k = 0; k < BYTES; k++) begin
            ld_data_s[8*k +: 8] = mem[AW'(ld_seq_s) + AW'(k)];
            ld_keep_s[k]        = (16'(k) < ld_nb_s);
        end
    end

    // Next-state logic: write pointer, ACK, retransmit rewind and the IDLE/EMIT machine.
    always_comb begin
        state_s = state_r;     snd_nxt_s = snd_nxt_r; retx_pend_s = retx_pend_r;
        seg_seq_s = seg_seq_r; seg_len_s = seg_len_r; rd_seq_s = rd_seq_r; rem_s = rem_r;
        tvalid_s = tvalid_r;   tlast_s = tlast_r;     tdata_s = tdata_r;   tkeep_s = tkeep_r;
        if (s_hs_s) begin
            wr_seq_s  = wr_seq_r + SEQ_BITS'(popcount(s_axis.tkeep));
            psh_seq_s = s_axis.tlast ? wr_seq_s : psh_seq_r;
        end else begin
            wr_seq_s  = wr_seq_r;
            psh_seq_s = psh_seq_r;
        end
        snd_una_s = ack_ok_s ? ack_num : snd_una_r;
        case (state_r)
            ST_IDLE: begin
                if (base_valid) begin
                    snd_una_s = seq_base; snd_nxt_s = seq_base;
                    wr_seq_s  = seq_base; psh_seq_s = seq_base;
                    retx_pend_s = 1'b0;
                end else if (retx_req) begin
                    snd_nxt_s = snd_una_s;
                end else if (start_s) begin
                    state_s   = ST_EMIT;
                    seg_seq_s = snd_nxt_r;
                    seg_len_s = len_s;
                    tvalid_s  = 1'b1; tdata_s = ld_data_s; tkeep_s = ld_keep_s;
                    tlast_s   = (ld_cnt_s <= 16'(BYTES));
                    rd_seq_s  = ld_seq_s + SEQ_BITS'(ld_nb_s);
                    rem_s     = ld_cnt_s - ld_nb_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                retx_pend_s = retx_pend_r || retx_req;
                if (m_hs_s && tlast_r) begin
                    // A rewind requested mid-segment takes effect as the segment completes.
                    state_s     = ST_IDLE;
                    tvalid_s    = 1'b0;
                    tlast_s     = 1'b0;
                    retx_pend_s = 1'b0;
                    snd_nxt_s   = (retx_pend_r || retx_req) ? snd_una_s : snd_nxt_r + SEQ_BITS'(seg_len_r);
                end else if (m_hs_s) begin
                    tdata_s  = ld_data_s; tkeep_s = ld_keep_s;
                    tlast_s  = (ld_cnt_s <= 16'(BYTES));
                    rd_seq_s = ld_seq_s + SEQ_BITS'(ld_nb_s);
                    rem_s    = ld_cnt_s - ld_nb_s;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
        unacked_s = snd_nxt_s - snd_una_s;
    end

    // Retransmit buffer write: each kept byte lands at its own sequence position.
    always_ff @(posedge clk) begin
        if (s_hs_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (s_axis.tkeep[k]) mem[AW'(wr_seq_r) + AW'(k)] <= s_axis.tdata[8*k +: 8];
            end
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            snd_una_r <= {SEQ_BITS{1'b0}}; snd_nxt_r <= {SEQ_BITS{1'b0}};
            wr_seq_r  <= {SEQ_BITS{1'b0}}; psh_seq_r <= {SEQ_BITS{1'b0}};
            seg_seq_r <= {SEQ_BITS{1'b0}}; unacked_r <= {SEQ_BITS{1'b0}};
            rd_seq_r  <= {SEQ_BITS{1'b0}};
            seg_len_r <= 16'd0;  rem_r   <= 16'd0;
            retx_pend_r <= 1'b0; tvalid_r <= 1'b0; tlast_r <= 1'b0;
            tdata_r   <= {DATA_WIDTH{1'b0}};
            tkeep_r   <= {BYTES{1'b0}};
        end else begin
            state_r   <= state_s;
            snd_una_r <= snd_una_s; snd_nxt_r <= snd_nxt_s;
            wr_seq_r  <= wr_seq_s;  psh_seq_r <= psh_seq_s;
            seg_seq_r <= seg_seq_s; unacked_r <= unacked_s;
            rd_seq_r  <= rd_seq_s;
            seg_len_r <= seg_len_s; rem_r   <= rem_s;
            retx_pend_r <= retx_pend_s; tvalid_r <= tvalid_s; tlast_r <= tlast_s;
            tdata_r   <= tdata_s;
            tkeep_r   <= tkeep_s;
        end
    end

    assign s_axis.tready = tready_s;
    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;
    assign m_axis.tkeep  = tkeep_r;
    assign m_axis.tlast  = tlast_r;
    assign m_axis.tuser  = 1'b0;
    assign seg_seq       = seg_seq_r;
    assign seg_len       = seg_len_r;
    assign unacked       = unacked_r;
endmodule

// File: tb/tb_tcp_tx_segmenter.sv
// Directed bench for tcp_tx_segmenter: expected segments queued at stimulus time, checked as beats leave.
module tb_tcp_tx_segmenter;
    localparam int DW    = 32;
    localparam int BYTES = DW / 8;
    localparam int MSS   = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seq_base, ack_num, window_size, seg_seq, unacked;
    logic        base_valid, ack_valid, retx_req;
    logic [15:0] seg_len;

    axi_stream_if #(.DATA_WIDTH(DW)) s_axis ();
    axi_stream_if #(.DATA_WIDTH(DW)) m_axis ();

    tcp_tx_segmenter #(.DATA_WIDTH(DW), .DEPTH(1024), .SEQ_BITS(32), .MSS(MSS)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .m_axis(m_axis),
        .seq_base(seq_base), .base_valid(base_valid), .ack_num(ack_num), .ack_valid(ack_valid),
        .window_size(window_size), .retx_req(retx_req),
        .seg_seq(seg_seq), .seg_len(seg_len), .unacked(unacked)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          seg_done = 0;
    logic [7:0]  model [logic [31:0]];
    logic [31:0] exp_seq_q [$];
    logic [15:0] exp_len_q [$];
    logic [31:0] wr_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_seg(input logic [31:0] s, input logic [15:0] l);
        exp_seq_q.push_back(s);
        exp_len_q.push_back(l);
    endtask

    // Monitor: every accepted output beat is checked against the queued header and the byte model.
    logic        mon_in_seg = 1'b0;
    logic [31:0] mon_hdr_seq, mon_cur;
    logic [15:0] mon_hdr_len, mon_rem;
    always @(negedge clk) begin
        if (rst_n && m_axis.tvalid && m_axis.tready) begin
            logic [31:0] exp_data, mask;
            logic [3:0]  exp_keep;
            int          nb;
            if (!mon_in_seg) begin
                chk("seg_expected", exp_seq_q.size() != 0, 1'b1);
                if (exp_seq_q.size() != 0) begin
                    mon_hdr_seq = exp_seq_q.pop_front();
                    mon_hdr_len = exp_len_q.pop_front();
                end else begin
                    mon_hdr_seq = seg_seq;
                    mon_hdr_len = seg_len;
                end
                chk("seg_len", seg_len, mon_hdr_len);
                mon_cur    = mon_hdr_seq;
                mon_rem    = mon_hdr_len;
                mon_in_seg = 1'b1;
            end
            chk("seg_seq", seg_seq, mon_hdr_seq);
            nb       = (mon_rem >= 16'(BYTES)) ? BYTES : int'(mon_rem);
            exp_data = 32'd0;
            mask     = 32'd0;
            exp_keep = 4'd0;
            for (int k = 0; k < BYTES; k++) begin
                if (k < nb) begin
                    exp_keep[k] = 1'b1;
                    mask[8*k +: 8] = 8'hFF;
                    if (model.exists(mon_cur + 32'(k))) exp_data[8*k +: 8] = model[mon_cur + 32'(k)];
                end
            end
            chk("tkeep", m_axis.tkeep, exp_keep);
            chk("tlast", m_axis.tlast, mon_rem <= 16'(BYTES));
            chk("tdata", m_axis.tdata & mask, exp_data);
            chk("tuser", m_axis.tuser, 1'b0);
            mon_cur = mon_cur + 32'(nb);
            mon_rem = mon_rem - 16'(nb);
            if (mon_rem == 16'd0) begin
                mon_in_seg = 1'b0;
                seg_done++;
            end
        end
    end

    task automatic send_bytes(input int n, input bit last);
        for (int off = 0; off < n; off += BYTES) begin
            int          nb;
            int          b;
            logic [31:0] d;
            nb = (n - off >= BYTES) ? BYTES : n - off;
            d  = $urandom;
            for (int k = 0; k < BYTES; k++) begin
                s_axis.tkeep[k] = (k < nb);
                if (k < nb) model[wr_ptr + 32'(k)] = d[8*k +: 8];
            end
            s_axis.tdata  = d;
            s_axis.tlast  = last && (off + nb == n);
            s_axis.tvalid = 1'b1;
            b = 0;
            @(negedge clk);
            while (!s_axis.tready && b < 3000) begin
                @(negedge clk);
                b++;
            end
            chk("s_axis_handshake", s_axis.tready, 1'b1);
            @(posedge clk);
            #1;
            wr_ptr = wr_ptr + 32'(nb);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_segs(input int target);
        int b;
        b = 0;
        while (seg_done < target && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("segments_done", seg_done >= target, 1'b1);
    endtask

    task automatic pulse_ack(input logic [31:0] a, input bit retx);
        ack_num   = a;
        ack_valid = 1'b1;
        retx_req  = retx;
        @(posedge clk);
        #1;
        ack_valid = 1'b0;
        retx_req  = 1'b0;
    endtask

    task automatic restart(input logic [31:0] base, input logic [31:0] win);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        window_size = win;
        seq_base    = base;
        base_valid  = 1'b1;
        @(posedge clk);
        #1;
        base_valid = 1'b0;
        wr_ptr     = base;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        rst_n = 1'b0; seq_base = 32'd0; base_valid = 1'b0; ack_num = 32'd0; ack_valid = 1'b0;
        window_size = 32'd0; retx_req = 1'b0; wr_ptr = 32'd0;
        s_axis.tvalid = 1'b0; s_axis.tdata = 32'd0; s_axis.tkeep = 4'd0; s_axis.tlast = 1'b0;
        s_axis.tuser = 1'b0; m_axis.tready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_axis.tready, 1'b0);
        chk("rst_tvalid", m_axis.tvalid, 1'b0);
        chk("rst_tlast", m_axis.tlast, 1'b0);
        chk("rst_tdata", m_axis.tdata, 32'd0);
        chk("rst_tkeep", m_axis.tkeep, 4'd0);
        chk("rst_seg_seq", seg_seq, 32'd0);
        chk("rst_seg_len", seg_len, 16'd0);
        chk("rst_unacked", unacked, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_tready_after_rst", s_axis.tready, 1'b1);

        // Basic segmentation.
        restart(32'h1000, 32'd4096);
        s0 = seg_done;
        expect_seg(32'h1000, 16'd64); expect_seg(32'h1040, 16'd64);
        expect_seg(32'h1080, 16'd64); expect_seg(32'h10C0, 16'd8);
        send_bytes(200, 1'b1);
        wait_segs(s0 + 4);
        chk("basic_unacked", unacked, 32'd200);

        // Window limit, ignored duplicate/beyond ACKs, then window reopens.
        restart(32'h1000, 32'd100);
        s0 = seg_done;
        expect_seg(32'h1000, 16'd64); expect_seg(32'h1040, 16'd36);
        send_bytes(200, 1'b1);
        wait_segs(s0 + 2);
        repeat (40) @(posedge clk);
        #1;
        chk("win_stall_unacked", unacked, 32'd100);
        pulse_ack(32'h1000, 1'b0);
        chk("dup_ack_ignored", unacked, 32'd100);
        pulse_ack(32'h1065, 1'b0);
        chk("beyond_ack_ignored", unacked, 32'd100);
        expect_seg(32'h1064, 16'd64); expect_seg(32'h10A4, 16'd36);
        pulse_ack(32'h1064, 1'b0);
        wait_segs(s0 + 4);
        chk("win_final_unacked", unacked, 32'd100);

        // Buffer full with window 0, then window opens and an ACK frees space.
        restart(32'h1000, 32'd0);
        s0 = seg_done;
        send_bytes(1024, 1'b0);
        s_axis.tdata = $urandom; s_axis.tkeep = 4'hF; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
        for (int k = 0; k < BYTES; k++) model[wr_ptr + 32'(k)] = s_axis.tdata[8*k +: 8];
        repeat (10) @(negedge clk);
        chk("full_s_tready", s_axis.tready, 1'b0);
        @(posedge clk);
        #1;
        pulse_ack(32'h2000, 1'b0);
        @(negedge clk);
        chk("full_ack_ignored", unacked, 32'd0);
        chk("full_s_tready_after_bad_ack", s_axis.tready, 1'b0);
        for (int i = 0; i < 16; i++) expect_seg(32'h1000 + 32'(64 * i), 16'd64);
        expect_seg(32'h1400, 16'd6);
        @(posedge clk);
        #1;
        window_size = 32'd4096;
        wait_segs(s0 + 1);
        pulse_ack(32'h1040, 1'b0);
        @(negedge clk);
        chk("s_tready_after_ack", s_axis.tready, 1'b1);
        @(posedge clk);
        #1;
        wr_ptr = wr_ptr + 32'd4;
        s_axis.tvalid = 1'b0;
        send_bytes(2, 1'b1);
        wait_segs(s0 + 17);
        chk("full_final_unacked", unacked, 32'd966);

        // Go-back-N: ACK and retransmit request on the same edge.
        restart(32'h1000, 32'd4096);
        s0 = seg_done;
        expect_seg(32'h1000, 16'd64); expect_seg(32'h1040, 16'd64);
        send_bytes(128, 1'b1);
        wait_segs(s0 + 2);
        expect_seg(32'h1040, 16'd64);
        pulse_ack(32'h1040, 1'b1);
        wait_segs(s0 + 3);
        chk("retx_unacked", unacked, 32'd64);

        // Sequence and buffer-index wrap, plus start latency after the push beat.
        restart(32'hFFFF_FFF0, 32'd4096);
        s0 = seg_done;
        expect_seg(32'hFFFF_FFF0, 16'd40);
        send_bytes(40, 1'b1);
        @(negedge clk);
        chk("latency_edge1_tvalid", m_axis.tvalid, 1'b0);
        @(negedge clk);
        chk("latency_edge2_tvalid", m_axis.tvalid, 1'b1);
        wait_segs(s0 + 1);
        chk("wrap_unacked", unacked, 32'd40);
        pulse_ack(32'h0000_0018, 1'b0);
        chk("wrap_ack_unacked", unacked, 32'd0);

        // Two short pushes 20 cycles apart.
        restart(32'h1000, 32'd4096);
        s0 = seg_done;
        expect_seg(32'h1000, 16'd10);
`ifndef TCP_TX_NAGLE_EN
        expect_seg(32'h100A, 16'd10);
`endif
        send_bytes(10, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        send_bytes(10, 1'b1);
`ifdef TCP_TX_NAGLE_EN
        repeat (30) @(posedge clk);
        #1;
        chk("nagle_held", seg_done, s0 + 1);
        expect_seg(32'h100A, 16'd10);
        pulse_ack(32'h100A, 1'b0);
        wait_segs(s0 + 2);
        chk("nagle_unacked", unacked, 32'd10);
`else
        wait_segs(s0 + 2);
        chk("push_unacked", unacked, 32'd20);
`endif

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_seq_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
